// File: rtl/branch_unit_if.sv
// Issue/broadcast bundle between the branch RS, the branch unit, the CDB arbiter and the ROB.
// Handshakes: issue is level-held by the RS until resp pulses; a CDB transfer occurs when cdb_valid && cdb_ack.
interface branch_unit_if #(
  parameter int ROB_DEPTH = 4
);
  localparam int TW = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;

  logic          comp_issue;
  logic [31:0]   instr_in;
  logic [31:0]   data_A_in;
  logic [31:0]   data_B_in;
  logic [31:0]   pc_in;
  logic [31:0]   imm_in;
  logic [TW-1:0] tag_dest_in;
  logic          resp;
  logic          busy;
  logic          cdb_valid;
  logic          cdb_ack;
  logic [TW-1:0] cdb_tag;
  logic [31:0]   cdb_data;
  logic          br_taken;
  logic [31:0]   br_target;
  logic          br_mispredict;
  logic [31:0]   br_redirect_pc;

  modport slave (
    input  comp_issue, instr_in, data_A_in, data_B_in, pc_in, imm_in, tag_dest_in, cdb_ack,
    output resp, busy, cdb_valid, cdb_tag, cdb_data,
           br_taken, br_target, br_mispredict, br_redirect_pc
  );

  modport master (
    output comp_issue, instr_in, data_A_in, data_B_in, pc_in, imm_in, tag_dest_in, cdb_ack,
    input  resp, busy, cdb_valid, cdb_tag, cdb_data,
           br_taken, br_target, br_mispredict, br_redirect_pc
  );
endinterface

// File: rtl/branch_unit.sv
// Branch execution stage: capture, resolve, broadcast on the CDB, then release the RS entry.
// Optional BRANCH_UNIT_BTFN_EN: backward-taken/forward-not-taken prediction instead of all-not-taken.
module branch_unit #(
  parameter int ROB_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  branch_unit_if.slave        bu,
  output logic [1:0]          dbg_state_o
);
  localparam int TW = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {IDLE, EXEC, BCAST, DONE} state_e;

  state_e state_q, state_d;

  logic [6:0]    opcode_q;
  logic [2:0]    funct3_q;
  logic [31:0]   a_q, b_q, pc_q, imm_q;
  logic [TW-1:0] tag_q;

  logic        taken_q, taken_d;
  logic [31:0] target_q, target_d;
  logic [31:0] link_q, link_d;
  logic        mispredict_q, mispredict_d;
  logic [31:0] redirect_q, redirect_d;

  logic        unused_instr_bits;
  assign unused_instr_bits = ^{bu.instr_in[31:15], bu.instr_in[11:7]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bu.comp_issue) state_d = EXEC;
      EXEC:    state_d = BCAST;
      BCAST:   if (bu.cdb_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flush overrides everything, including a concurrent CDB grant.
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode_q <= '0;
      funct3_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
      tag_q    <= '0;
    end else if (state_q == IDLE && bu.comp_issue && !flush) begin
      opcode_q <= bu.instr_in[6:0];
      funct3_q <= bu.instr_in[14:12];
      a_q      <= bu.data_A_in;
      b_q      <= bu.data_B_in;
      pc_q     <= bu.pc_in;
      imm_q    <= bu.imm_in;
      tag_q    <= bu.tag_dest_in;
    end
  end

  logic [31:0] pc_plus4, pc_plus_imm, jalr_sum;
  logic        is_cond, is_jump, predicted;

  assign pc_plus4    = pc_q + 32'd4;
  assign pc_plus_imm = pc_q + imm_q;
  assign jalr_sum    = a_q + imm_q;

  always_comb begin
    taken_d  = 1'b0;
    target_d = pc_plus4;
    link_d   = '0;
    is_cond  = 1'b0;
    is_jump  = 1'b0;
    case (opcode_q)
      OPC_BRANCH: begin
        is_cond  = 1'b1;
        target_d = pc_plus_imm;
        case (funct3_q)
          3'b000:  taken_d = (a_q == b_q);
          3'b001:  taken_d = (a_q != b_q);
          3'b100:  taken_d = ($signed(a_q) <  $signed(b_q));
          3'b101:  taken_d = ($signed(a_q) >= $signed(b_q));
          3'b110:  taken_d = (a_q <  b_q);
          3'b111:  taken_d = (a_q >= b_q);
          default: taken_d = 1'b0;
        endcase
      end
      OPC_JAL: begin
        is_jump  = 1'b1;
        taken_d  = 1'b1;
        target_d = pc_plus_imm;
        link_d   = pc_plus4;
      end
      OPC_JALR: begin
        is_jump  = 1'b1;
        taken_d  = 1'b1;
        target_d = jalr_sum & ~32'h1;
        link_d   = pc_plus4;
      end
      default: ;
    endcase
  end

`ifdef BRANCH_UNIT_BTFN_EN
  // Sign of the offset tells direction; jumps are always predicted taken to their target.
  assign predicted = is_jump | (is_cond & imm_q[31]);
`else
  logic unused_pred_inputs;
  assign unused_pred_inputs = is_cond ^ is_jump;
  assign predicted = 1'b0;
`endif

  assign mispredict_d = taken_d ^ predicted;
  assign redirect_d   = taken_d ? target_d : pc_plus4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taken_q      <= 1'b0;
      target_q     <= '0;
      link_q       <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else if (state_q == EXEC) begin
      taken_q      <= taken_d;
      target_q     <= target_d;
      link_q       <= link_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
    end
  end

  // Result sideband is zeroed outside BCAST so the ROB never sees stale data.
  logic bcast;
  assign bcast             = (state_q == BCAST);
  assign bu.cdb_valid      = bcast;
  assign bu.cdb_tag        = bcast ? tag_q        : '0;
  assign bu.cdb_data       = bcast ? link_q       : '0;
  assign bu.br_taken       = bcast ? taken_q      : 1'b0;
  assign bu.br_target      = bcast ? target_q     : '0;
  assign bu.br_mispredict  = bcast ? mispredict_q : 1'b0;
  assign bu.br_redirect_pc = bcast ? redirect_q   : '0;
  assign bu.resp           = (state_q == DONE);
  assign bu.busy           = (state_q != IDLE);
  assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: vector table through a scoreboard queue plus stall/flush/reset sequences.
module tb_branch_unit;
  localparam int EW = 2 + 32 + 1 + 32 + 1 + 32;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_ALU    = 7'b0110011;

  typedef struct {
    logic [31:0] instr, a, b, pc, imm;
    logic [1:0]  tag;
    logic        taken;
    logic [31:0] target, data;
    logic        is_cond, is_jump;
  } vec_t;

  logic clk, rst, flush;
  logic [1:0] dbg_state;
  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  vec_t vecs[11];

  branch_unit_if #(.ROB_DEPTH(4)) bu ();

  branch_unit #(.ROB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bu(bu), .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_instr(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, op};
  endfunction

  function automatic vec_t mk_vec(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] pc, input logic [31:0] imm,
                                  input logic [1:0] tag, input logic taken,
                                  input logic [31:0] target, input logic [31:0] data);
    vec_t v;
    v.instr = mk_instr(op, f3); v.a = a; v.b = b; v.pc = pc; v.imm = imm;
    v.tag = tag; v.taken = taken; v.target = target; v.data = data;
    v.is_cond = (op == OPC_BRANCH);
    v.is_jump = (op == OPC_JAL) || (op == OPC_JALR);
    return v;
  endfunction

  // Expected record: {tag, data, taken, target, mispredict, redirect}.
  function automatic logic [EW-1:0] pack_exp(input vec_t v);
    logic pred;
`ifdef BRANCH_UNIT_BTFN_EN
    pred = v.is_jump || (v.is_cond && v.imm[31]);
`else
    pred = 1'b0;
`endif
    return {v.tag, v.data, v.taken, v.target, (v.taken != pred),
            (v.taken ? v.target : v.pc + 32'd4)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string nm);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_sb actual=output expected=empty_queue", nm);
      return;
    end
    e = exp_q.pop_front();
    check({nm, "_tag"},      {30'd0, bu.cdb_tag},       {30'd0, e[99:98]});
    check({nm, "_data"},     bu.cdb_data,               e[97:66]);
    check({nm, "_taken"},    {31'd0, bu.br_taken},      {31'd0, e[65]});
    check({nm, "_target"},   bu.br_target,              e[64:33]);
    check({nm, "_mispred"},  {31'd0, bu.br_mispredict}, {31'd0, e[32]});
    check({nm, "_redirect"}, bu.br_redirect_pc,         e[31:0]);
  endtask

  task automatic drive(input vec_t v);
    bu.instr_in    = v.instr;
    bu.data_A_in   = v.a;
    bu.data_B_in   = v.b;
    bu.pc_in       = v.pc;
    bu.imm_in      = v.imm;
    bu.tag_dest_in = v.tag;
    bu.comp_issue  = 1'b1;
  endtask

  task automatic run_op(input vec_t v, input int stall, input string nm);
    int n;
    logic [EW-1:0] e;
    drive(v);
    bu.cdb_ack = (stall == 0);
    exp_q.push_back(pack_exp(v));
    @(negedge clk);
    check({nm, "_lat1_valid"}, {31'd0, bu.cdb_valid}, 32'd0);
    @(negedge clk);
    n = 0;
    while (!bu.cdb_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_lat2_extra"}, n, 0);
    if (!bu.cdb_valid) begin
      void'(exp_q.pop_front());
      bu.comp_issue = 1'b0;
      bu.cdb_ack = 1'b0;
      return;
    end
    e = exp_q[0];
    for (int i = 0; i < stall; i++) begin
      check({nm, "_stall_valid"},  {31'd0, bu.cdb_valid}, 32'd1);
      check({nm, "_stall_resp"},   {31'd0, bu.resp},      32'd0);
      check({nm, "_stall_target"}, bu.br_target,          e[64:33]);
      check({nm, "_stall_redir"},  bu.br_redirect_pc,     e[31:0]);
      @(negedge clk);
    end
    bu.cdb_ack = 1'b1;
    sb_check(nm);
    @(negedge clk);
    check({nm, "_resp"},       {31'd0, bu.resp},      32'd1);
    check({nm, "_done_valid"}, {31'd0, bu.cdb_valid}, 32'd0);
    bu.cdb_ack = 1'b0;
    @(negedge clk);
    check({nm, "_resp_once"},    {31'd0, bu.resp}, 32'd0);
    check({nm, "_no_recapture"}, {31'd0, bu.busy}, 32'd0);
    bu.comp_issue = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = mk_vec(OPC_BRANCH, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 2'd0, 1'b1, 32'h120, 32'h0);
    vecs[1]  = mk_vec(OPC_BRANCH, 3'b100, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h10, 2'd1, 1'b1, 32'h210, 32'h0);
    vecs[2]  = mk_vec(OPC_BRANCH, 3'b110, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h10, 2'd2, 1'b0, 32'h210, 32'h0);
    vecs[3]  = mk_vec(OPC_JALR,   3'b000, 32'h2003, 32'd0, 32'h40, 32'h4, 2'd3, 1'b1, 32'h2006, 32'h44);
    vecs[4]  = mk_vec(OPC_JAL,    3'b000, 32'd0, 32'd0, 32'h1000, 32'hFFFFFFF0, 2'd0, 1'b1, 32'hFF0, 32'h1004);
    vecs[5]  = mk_vec(OPC_BRANCH, 3'b101, 32'hFFFFFFFF, 32'd0, 32'h300, 32'hFFFFFF00, 2'd1, 1'b0, 32'h200, 32'h0);
    vecs[6]  = mk_vec(OPC_BRANCH, 3'b111, 32'hFFFFFFFF, 32'd0, 32'h300, 32'hFFFFFF00, 2'd2, 1'b1, 32'h200, 32'h0);
    vecs[7]  = mk_vec(OPC_BRANCH, 3'b010, 32'd3, 32'd3, 32'h500, 32'h8, 2'd3, 1'b0, 32'h508, 32'h0);
    vecs[8]  = mk_vec(OPC_ALU,    3'b000, 32'd1, 32'd2, 32'hFFFFFFFC, 32'h40, 2'd0, 1'b0, 32'h0, 32'h0);
    vecs[9]  = mk_vec(OPC_BRANCH, 3'b001, 32'd5, 32'd5, 32'h80, 32'hFFFFFFE0, 2'd1, 1'b0, 32'h60, 32'h0);
    vecs[10] = mk_vec(OPC_BRANCH, 3'b001, 32'd1, 32'd2, 32'hFFFFFFF0, 32'h20, 2'd2, 1'b1, 32'h10, 32'h0);

    rst = 1'b0; flush = 1'b0;
    bu.comp_issue = 1'b0; bu.cdb_ack = 1'b0;
    bu.instr_in = '0; bu.data_A_in = '0; bu.data_B_in = '0;
    bu.pc_in = '0; bu.imm_in = '0; bu.tag_dest_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",     {31'd0, bu.busy},          32'd0);
    check("rst_valid",    {31'd0, bu.cdb_valid},     32'd0);
    check("rst_resp",     {31'd0, bu.resp},          32'd0);
    check("rst_data",     bu.cdb_data,               32'd0);
    check("rst_target",   bu.br_target,              32'd0);
    check("rst_redirect", bu.br_redirect_pc,         32'd0);
    check("rst_taken",    {31'd0, bu.br_taken},      32'd0);
    check("rst_mispred",  {31'd0, bu.br_mispredict}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_op(vecs[i], 0, $sformatf("vec%0d", i));

    // Random CDB stalls on a few table entries.
    for (int i = 0; i < 3; i++) run_op(vecs[$urandom_range(0, 9)], $urandom_range(1, 3), $sformatf("rstall%0d", i));

    // Five cycles without grant, ack on the sixth.
    run_op(vecs[0], 5, "stall5");

    // Flush coinciding with the CDB grant: no DONE, no resp.
    drive(vecs[1]);
    repeat (2) @(negedge clk);
    check("flush_in_bcast", {31'd0, bu.cdb_valid}, 32'd1);
    bu.cdb_ack = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_idle",  {31'd0, bu.busy},      32'd0);
    check("flush_valid", {31'd0, bu.cdb_valid}, 32'd0);
    check("flush_resp",  {31'd0, bu.resp},      32'd0);
    flush = 1'b0; bu.cdb_ack = 1'b0; bu.comp_issue = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("flush_no_resp", {31'd0, bu.resp}, 32'd0);
    end
    run_op(vecs[3], 0, "post_flush");

    // Asynchronous reset between edges while in EXEC.
    drive(vecs[0]);
    bu.cdb_ack = 1'b1;
    @(negedge clk);
    check("pre_rst_busy", {31'd0, bu.busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_busy",   {31'd0, bu.busy},      32'd0);
    check("async_valid",  {31'd0, bu.cdb_valid}, 32'd0);
    check("async_resp",   {31'd0, bu.resp},      32'd0);
    check("async_state",  {30'd0, dbg_state},    32'd0);
    check("async_target", bu.br_target,          32'd0);
    bu.comp_issue = 1'b0; bu.cdb_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(vecs[10], 0, "bne_wrap");

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
